// File: rtl/ram_output_drain_if.sv
// +----------------------------------------------------------------------------+
// | ram_output_drain_if : RAM read port plus valid/ready output stream.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ram_output_drain_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]      ram_di;
  logic [WIDTH-1:0]      ram_dout;
  logic                  m_valid;
  logic                  m_ready;
  logic [WIDTH-1:0]      m_data;
  logic                  m_last;

  modport master (
    output ram_en, ram_we, ram_addr, ram_di,
    input  ram_dout,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  ram_en, ram_we, ram_addr, ram_di,
    output ram_dout,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

`default_nettype wire

// File: rtl/ram_output_drain.sv
// +----------------------------------------------------------------------------+
// | ram_output_drain : streams words 0..N-1 out of the output RAM.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_output_drain #(
  parameter int COLS       = 4,
  parameter int ROWS       = 2,
  parameter int Y_BITS     = 16,
  parameter int DEPTH      = COLS * ROWS,
  parameter int WIDTH      = Y_BITS,
  parameter int LATENCY    = 2,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_words,
  output logic                  busy,
  output logic                  done,
  ram_output_drain_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH:0]   C_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH:0]   cnt_max_q, cnt_max_d;
  logic [LATENCY-1:0]    vp_q, vp_d;
  logic [LATENCY-1:0]    lp_q, lp_d;
  logic                  done_q, done_d;

  logic w_en;
  logic w_issue;
  logic w_last_issue;
  logic w_hs_last;

  // The RAM enable doubles as pipeline advance: a stalled head beat freezes
  // the RAM output register, its delay line and the valid/last pipes together.
  always_comb begin
    w_en         = (state_q != S_IDLE) & (~vp_q[LATENCY-1] | bus.m_ready);
    w_issue      = (state_q == S_RUN) & w_en;
    w_last_issue = w_issue & (issued_q == (cnt_max_q - C_CNT_ONE));
    w_hs_last    = vp_q[LATENCY-1] & bus.m_ready & lp_q[LATENCY-1];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    issued_d  = issued_q;
    cnt_max_d = cnt_max_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          addr_d    = '0;
          issued_d  = '0;
          cnt_max_d = ((n_words == '0) || (n_words > C_DEPTH)) ? C_DEPTH : n_words;
        end
      end
      S_RUN: begin
        if (w_issue) begin
          issued_d = issued_q + C_CNT_ONE;
          // Address parks on the final word so the RAM never sees cnt_max.
          if (w_last_issue) begin
            state_d = S_FLUSH;
          end else begin
            addr_d = addr_q + C_ADDR_ONE;
          end
        end
      end
      S_FLUSH: begin
        if (w_hs_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  generate
    if (LATENCY == 1) begin : g_pipe_single
      always_comb begin
        vp_d = vp_q;
        lp_d = lp_q;
        if (w_en) begin
          vp_d = w_issue;
          lp_d = w_last_issue;
        end
      end
    end else begin : g_pipe_shift
      always_comb begin
        vp_d = vp_q;
        lp_d = lp_q;
        if (w_en) begin
          vp_d = {vp_q[LATENCY-2:0], w_issue};
          lp_d = {lp_q[LATENCY-2:0], w_last_issue};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      issued_q  <= '0;
      cnt_max_q <= '0;
      vp_q      <= '0;
      lp_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      issued_q  <= issued_d;
      cnt_max_q <= cnt_max_d;
      vp_q      <= vp_d;
      lp_q      <= lp_d;
      done_q    <= done_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign bus.ram_en   = w_en;
  assign bus.ram_we   = 1'b0;
  assign bus.ram_addr = addr_q;
  assign bus.ram_di   = '0;
  assign bus.m_valid  = vp_q[LATENCY-1];
  assign bus.m_last   = lp_q[LATENCY-1];
  assign bus.m_data   = bus.ram_dout;

endmodule

`default_nettype wire

// File: tb/tb_ram_output_drain.sv
// +----------------------------------------------------------------------------+
// | tb_ram_output_drain : directed and random-ready checks of the RAM drain.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram_output_drain;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [3:0]  nw_a = '0, nw_b = '0;
  logic        busy_a, done_a, busy_b, done_b;
  logic        m_ready = 1'b0;
  logic        sel = 1'b0;

  logic [15:0] mem_a [DEPTH];
  logic [15:0] mem_b [DEPTH];
  logic [15:0] sa [2];
  logic [15:0] sb [3];

  int n_vec = 0;
  int n_err = 0;
  int lasts = 0;

  ram_output_drain_if #(.WIDTH(16), .ADDR_WIDTH(3)) ia ();
  ram_output_drain_if #(.WIDTH(16), .ADDR_WIDTH(3)) ib ();

  ram_output_drain #(.DEPTH(DEPTH), .WIDTH(16), .LATENCY(2), .ADDR_WIDTH(3)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .n_words(nw_a),
    .busy(busy_a), .done(done_a), .bus(ia.master)
  );

  ram_output_drain #(.DEPTH(DEPTH), .WIDTH(16), .LATENCY(3), .ADDR_WIDTH(3)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .n_words(nw_b),
    .busy(busy_b), .done(done_b), .bus(ib.master)
  );

  always #5 clk = ~clk;

  // RAM models: read register plus delay line, all gated by ram_en.
  always @(posedge clk) begin
    if (ia.ram_en) begin
      sa[0] <= mem_a[ia.ram_addr];
      sa[1] <= sa[0];
    end
    if (ib.ram_en) begin
      sb[0] <= mem_b[ib.ram_addr];
      sb[1] <= sb[0];
      sb[2] <= sb[1];
    end
  end

  assign ia.ram_dout = sa[1];
  assign ib.ram_dout = sb[2];
  assign ia.m_ready  = m_ready;
  assign ib.m_ready  = m_ready;

  logic        o_valid, o_last, o_busy, o_done;
  logic [15:0] o_data;
  logic [2:0]  o_addr;

  always_comb begin
    o_valid = sel ? ib.m_valid  : ia.m_valid;
    o_last  = sel ? ib.m_last   : ia.m_last;
    o_data  = sel ? ib.m_data   : ia.m_data;
    o_addr  = sel ? ib.ram_addr : ia.ram_addr;
    o_busy  = sel ? busy_b      : busy_a;
    o_done  = sel ? done_b      : done_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input bit s, input int i);
    return s ? mem_b[i % DEPTH] : mem_a[i % DEPTH];
  endfunction

  // mode 0: ready held high, 1: fixed toggle pattern, 2: random 50%.
  task automatic drain(input bit s, input int nreq, input int mode, input bit restart);
    int          exp_n, beat, cyc, lat;
    bit          got_done, seen_valid;
    logic        pv, pr, pl;
    logic [15:0] pd;
    logic [2:0]  pa;
    bit          tog [6];
    tog = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_n = ((nreq == 0) || (nreq > DEPTH)) ? DEPTH : nreq;
    lat   = s ? 3 : 2;
    sel   = s;
    @(negedge clk);
    if (s) begin start_b = 1'b1; nw_b = 4'(nreq); end
    else   begin start_a = 1'b1; nw_a = 4'(nreq); end
    m_ready = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    beat = 0; got_done = 0; seen_valid = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pa = '0;
    for (cyc = 0; cyc < 300 && !got_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = tog[cyc % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (restart && cyc == 3) begin start_a = 1'b1; nw_a = 4'd2; end
      else                           start_a = 1'b0;
      #1;
      if (pv && !pr) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data",  o_data,  pd);
        chk("hold_last",  o_last,  pl);
        chk("hold_addr",  o_addr,  pa);
      end
      if (mode == 0 && o_valid && !seen_valid) chk("first_valid_cyc", cyc, lat);
      if (o_valid) seen_valid = 1;
      if (o_done) begin
        got_done = 1;
        chk("done_beats", beat, exp_n);
        chk("done_busy",  o_busy, 0);
        if (mode == 0) chk("done_cyc", cyc, lat + exp_n);
      end else begin
        chk("busy_window", o_busy, 1);
        chk("addr_range", 32'(o_addr) < 32'(exp_n), 1);
      end
      if (o_valid && m_ready) begin
        chk("beat_data", o_data, exp_word(s, beat));
        chk("beat_last", o_last, beat == exp_n - 1);
        if (o_last) lasts++;
        beat++;
      end
      pv = o_valid; pr = m_ready; pd = o_data; pl = o_last; pa = o_addr;
    end
    start_a = 1'b0;
    if (!got_done) chk("timeout_done", 0, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("no_extra_done", o_done,  0);
      chk("idle_busy",     o_busy,  0);
      chk("idle_valid",    o_valid, 0);
    end
  endtask

  initial begin
    int  beat;
    bit  stalled;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 16'(100 + i);
      mem_b[i] = 16'(200 + 3 * i);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",   busy_a, 0);
    chk("rst_done",   done_a, 0);
    chk("rst_en",     ia.ram_en, 0);
    chk("rst_addr",   ia.ram_addr, 0);
    chk("rst_valid",  ia.m_valid, 0);
    chk("rst_last",   ia.m_last, 0);
    chk("rst_we",     ia.ram_we, 0);
    chk("rst_b_busy", busy_b, 0);
    @(negedge clk);
    rstn = 1'b1;

    drain(1'b0, 0, 0, 1'b0);
    drain(1'b0, 3, 1, 1'b0);
    drain(1'b0, 1, 0, 1'b0);
    drain(1'b0, 5, 0, 1'b1);

    // Async reset while the third beat is stalled.
    sel = 1'b0;
    @(negedge clk);
    start_a = 1'b1; nw_a = 4'd5; m_ready = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    beat = 0; stalled = 0;
    for (int c = 0; c < 40 && !stalled; c++) begin
      if (c > 0) @(negedge clk);
      m_ready = (beat < 2);
      #1;
      if (ia.m_valid && m_ready) beat++;
      else if (ia.m_valid && beat == 2) stalled = 1;
    end
    chk("rst_stall_reached", stalled, 1);
    chk("rst_stall_data", ia.m_data, 102);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy",  busy_a, 0);
    chk("arst_done",  done_a, 0);
    chk("arst_en",    ia.ram_en, 0);
    chk("arst_addr",  ia.ram_addr, 0);
    chk("arst_valid", ia.m_valid, 0);
    chk("arst_last",  ia.m_last, 0);
    @(negedge clk);
    rstn = 1'b1;

    drain(1'b0, 0, 0, 1'b0);
    drain(1'b0, 12, 0, 1'b0);

    lasts = 0;
    for (int r = 0; r < 1000; r++) drain(1'b1, $urandom_range(0, 15), 2, 1'b0);
    chk("last_count", lasts, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
